// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 controllers: round count, round-index width
// and the encrypt FSM state encoding.
package aes_pkg;

  localparam int AES256_NUM_ROUNDS = 14;
  localparam int ROUND_W           = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

endpackage

// File: rtl/aes_round_counter.sv
// Round-index counter with synchronous clear, increment and a terminal-count flag.
// Clear takes priority over increment.
module aes_round_counter #(
  parameter int W  = 4,
  parameter int TC = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_V);

endmodule

// File: rtl/aes256_round_ctrl.sv
// Sequencer for one AES-256 encryption pass: key capture, key-expansion drive,
// datapath round strobes and a result handshake with a completed-block counter.
//
//   state | meaning
//   IDLE  | waiting for a request; in_ready high
//   ROUND | rounds 0..NUM_ROUNDS, one per cycle, no stalls
//   DONE  | result valid; waits for out_ready, may chain straight into ROUND
module aes256_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_NUM_ROUNDS,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [255:0]       key_in,
  output logic [255:0]       ke_key,
  output logic               ke_enable,
  output logic [ROUND_W-1:0] ke_round_num,
  output logic               dp_load,
  output logic               dp_round_en,
  output logic               dp_last_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_done
);

  aes_state_e         state_q, state_d;
  logic [255:0]       ke_key_q, ke_key_d;
  logic [CNT_W-1:0]   blocks_done_q, blocks_done_d;
  logic               cnt_clr, cnt_inc, cnt_tc;
  logic [ROUND_W-1:0] round_cnt;

  aes_round_counter #(
    .W  (ROUND_W),
    .TC (NUM_ROUNDS)
  ) u_round_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (round_cnt),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ke_key_q      <= '0;
      blocks_done_q <= '0;
    end else begin
      state_q       <= state_d;
      ke_key_q      <= ke_key_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ke_key_d      = ke_key_q;
    blocks_done_d = blocks_done_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    in_ready      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ke_key_d = key_in;
          cnt_clr  = 1'b1;
          state_d  = ROUND;
        end
      end
      ROUND: begin
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        // Accepting a new key here only happens together with the result handshake
        in_ready = out_ready;
        if (out_ready) begin
          blocks_done_d = blocks_done_q + CNT_W'(1);
          if (in_valid) begin
            ke_key_d = key_in;
            cnt_clr  = 1'b1;
            state_d  = ROUND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ke_key        = ke_key_q;
  assign ke_enable     = (state_q == ROUND);
  assign ke_round_num  = (state_q == ROUND) ? round_cnt : '0;
  assign dp_load       = (state_q == ROUND) && (round_cnt == '0);
  assign dp_round_en   = (state_q == ROUND) && (round_cnt != '0);
  assign dp_last_round = (state_q == ROUND) && cnt_tc;
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q == ROUND) || (state_q == DONE);
  assign blocks_done   = blocks_done_q;

endmodule

// File: doc/aes256_round_ctrl.md
Name: aes256_round_ctrl

Overview:
Sequencer for one AES-256 encryption pass. It accepts a 256-bit key and a start request over a valid/ready handshake, registers the key, and drives the key-expansion unit (enable, round number, key) for rounds 0..14. In step with that, it issues load/round/last-round strobes to the round datapath and presents completion over an out_valid/out_ready handshake. It sits between the top-level block interface and the key-expansion and round datapath.

Parameters:
NUM_ROUNDS, 14, index of the final round; the round counter runs 0..NUM_ROUNDS.
CNT_W, 32, width of the completed-block status counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  new block request; key_in is valid
in_ready  output  1  controller can accept a request
key_in  input  256  cipher key, captured on accept
ke_key  output  256  registered key to the key-expansion key input; stable from accept until the next accept
ke_enable  output  1  key-expansion step enable
ke_round_num  output  4  round number to the key-expansion unit
dp_load  output  1  datapath: state <= block ^ round key 0
dp_round_en  output  1  datapath: perform one round using the current round key
dp_last_round  output  1  datapath: final round, MixColumns skipped
out_valid  output  1  ciphertext in the datapath state is final
out_ready  input  1  consumer accepts the result
busy  output  1  high in ROUND and DONE
blocks_done  output  CNT_W  count of handshaken results; wraps

Behaviour:
- Reset values: state=IDLE, round_cnt=0, ke_key=0, blocks_done=0. All strobes, out_valid and busy are 0; in_ready=1 after reset deasserts.
- FSM has three states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: ke_key<=key_in, round_cnt<=0, go to ROUND.
- ROUND:
  - ke_enable=1 and ke_round_num=round_cnt every cycle.
  - dp_load=(round_cnt==0).
  - dp_round_en=(round_cnt!=0).
  - dp_last_round=(round_cnt==NUM_ROUNDS).
  - round_cnt increments each cycle. At NUM_ROUNDS: round_cnt<=0, go to DONE.
  - No stalls: exactly NUM_ROUNDS+1 consecutive cycles.
- DONE:
  - out_valid=1, held until out_ready.
  - On out_ready: blocks_done+=1.
  - If in_valid is also high in the same cycle, the next block is accepted without an IDLE bubble: ke_key<=key_in, go to ROUND. Otherwise go to IDLE.
  - in_ready=out_ready in DONE (combinational).
- Outside ROUND: ke_enable=0 and ke_round_num=0. The key-expansion unit is therefore untouched and its round-0 key output tracks ke_key.
- Latency: accept at cycle T; ROUND occupies T+1..T+15; out_valid rises at T+16. With immediate out_ready, back-to-back throughput is 1 block per 16 cycles.
- ke_key changes only on accept. It is never modified while in ROUND or while out_valid is high without out_ready.
- in_valid during ROUND is ignored (in_ready=0). The requester holds its request.
- blocks_done wraps from 2^CNT_W-1 to 0.
- Reset mid-ROUND or mid-DONE: immediate return to reset values. No partial out_valid pulse. The pending result is discarded and blocks_done is cleared.
- All outputs except in_ready are functions of registered state only.

Decomposition:
- Shared package aes_pkg holds:
  - AES256_NUM_ROUNDS=14
  - the round-index width (4)
  - the FSM state enum {IDLE, ROUND, DONE}, 2-bit encoding
- One natural sub-module, aes_round_counter: 4-bit counter with clear, increment and terminal-count flag. It is reusable by a future decrypt controller.

Test Plan:
- Reset then idle: assert reset, release -> in_ready=1, out_valid=0, blocks_done=0, ke_enable=0 for 20 cycles.
- Single block, FIPS-197 C.3 key 000102…1f, connected to key expansion:
  - round 0 key = 000102030405060708090a0b0c0d0e0f
  - round 1 key = 101112131415161718191a1b1c1d1e1f
  - round 14 key = 24fc79ccbf0979e9371ac23c6d68de36
  - dp_load only at round_cnt=0; dp_last_round only at round_cnt=14; out_valid at T+16.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and ke_key stable, in_ready=0, blocks_done unchanged; then out_ready=1 -> blocks_done=1.
- Back-to-back: in_valid held with a second key while out_ready=1 in DONE -> second ROUND starts the next cycle with no IDLE cycle; ke_key updates to the second key; two results 16 cycles apart.
- Ignore during ROUND: pulse in_valid with key=all-ones at round_cnt=7 -> ke_key unchanged, round sequence completes normally.
- Mid-operation reset: assert reset at round_cnt=9 -> next cycle state IDLE, ke_enable=0, out_valid never rises, blocks_done=0; a new block after release completes in 16 cycles.
